// File: rtl/mock_pkg.sv
// mock_pkg: shared encodings and LFSR constants for the mock functional block
package mock_pkg;
  typedef enum logic [1:0] {
    MOCK_CONST = 2'd0,
    MOCK_PASS  = 2'd1,
    MOCK_SUM   = 2'd2,
    MOCK_PRED  = 2'd3
  } mock_mode_e;
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mock_state_e;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // feedback taps for x^8+x^6+x^5+x^4+1 on a left-shifting register: stages 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;
endpackage

// File: rtl/mock_lfsr.sv
// mock_lfsr: 8-bit Fibonacci LFSR that steps once per asserted adv
//   CLK  in  clock, rising edge
//   RST  in  asynchronous active-low reset, loads LFSR_SEED
//   adv  in  advance enable
//   lo   out low two bits of the current (pre-advance) state
module mock_lfsr
  import mock_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       adv,
  output logic [1:0] lo
);
  logic [7:0] q;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) q <= LFSR_SEED;
    else if (adv) q <= {q[6:0], ^(q & LFSR_TAPS)};
  assign lo = q[1:0];
endmodule

// File: rtl/mock_func.sv
// mock_func: start/ready mock function (const, pass, sum or predicate result)
//   CLK  in  clock, rising edge
//   RST  in  asynchronous active-low reset
//   ST   in  start request
//   IN   in  NIN packed WIDTH-bit operands, operand k = IN[k*WIDTH +: WIDTH]
//   RD   out idle/ready, result valid while high
//   RES  out result, updated only on the completion edge
// Define MOCK_RANDLAT_EN to add 0..3 pseudo-random extra cycles per operation.
module mock_func
  import mock_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int NIN       = 3,
  parameter int LATENCY   = 4,
  parameter int MODE      = 0,
  parameter int CONST_VAL = 2,
  parameter int SEL_IDX   = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ST,
  input  logic [NIN*WIDTH-1:0] IN,
  output logic                 RD,
  output logic [WIDTH-1:0]     RES
);
  localparam int CW = $clog2(LATENCY + 4) + 1;
  // second predicate operand index, kept legal when NIN=1 so the block still elaborates
  localparam int I1 = (NIN > 1) ? 1 : 0;
  mock_state_e state, state_nxt;
  logic [CW-1:0] cnt, lat0;
  logic [NIN*WIDTH-1:0] ops;
  logic [WIDTH-1:0] sum, f;
  logic go, done;
  assign go   = (state == IDLE) && ST;
  assign done = (state == BUSY) && (cnt == '0);
`ifdef MOCK_RANDLAT_EN
  logic [1:0] extra;
  mock_lfsr u_lfsr (
    .CLK (CLK),
    .RST (RST),
    .adv (go),
    .lo  (extra)
  );
  assign lat0 = CW'(LATENCY - 1) + CW'(extra);
`else
  assign lat0 = CW'(LATENCY - 1);
`endif
  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= IDLE;
    else state <= state_nxt;
  always_comb state_nxt = go ? BUSY : done ? IDLE : state;
  always_comb RD = (state == IDLE);
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      cnt <= '0;
      ops <= '0;
      RES <= '0;
    end else begin
      if (go) begin
        ops <= IN;
        cnt <= lat0;
      end else if (state == BUSY && cnt != '0) cnt <= cnt - CW'(1);
      if (done) RES <= f;
    end
  always_comb begin
    sum = '0;
    for (int k = 0; k < NIN; k++) sum = sum + ops[k*WIDTH +: WIDTH];
  end
  always_comb
    f = (MODE == int'(MOCK_CONST)) ? WIDTH'(CONST_VAL) :
        (MODE == int'(MOCK_PASS))  ? ops[SEL_IDX*WIDTH +: WIDTH] :
        (MODE == int'(MOCK_SUM))   ? sum :
        WIDTH'(ops[0 +: WIDTH] > ops[I1*WIDTH +: WIDTH]);
endmodule

// File: tb/tb_mock_func.sv
module tb_mock_func;
  localparam int W = 16, N = 3, L = 4;
  logic CLK = 1'b0, RST = 1'b0, ST = 1'b0;
  logic [N*W-1:0] IN = '0;
  logic [3:0] rd;
  logic [W-1:0] res [4];
  always #5 CLK = ~CLK;

  mock_func #(.MODE(0))              u0 (.CLK(CLK), .RST(RST), .ST(ST), .IN(IN), .RD(rd[0]), .RES(res[0]));
  mock_func #(.MODE(1), .SEL_IDX(2)) u1 (.CLK(CLK), .RST(RST), .ST(ST), .IN(IN), .RD(rd[1]), .RES(res[1]));
  mock_func #(.MODE(2))              u2 (.CLK(CLK), .RST(RST), .ST(ST), .IN(IN), .RD(rd[2]), .RES(res[2]));
  mock_func #(.MODE(3))              u3 (.CLK(CLK), .RST(RST), .ST(ST), .IN(IN), .RD(rd[3]), .RES(res[3]));

  typedef struct {
    logic [3:0][W-1:0] e;
    int lat;
  } exp_t;
  exp_t q[$];
  int total = 0, pass = 0;
  int mrem = 0, starts = 0, done_cnt = 0;
  int lo_cnt = 0, hi_run = 0, last_hi = -1;
  logic prev = 1'b1;
  logic [3:0][W-1:0] cur = '0;
  logic [7:0] mlfsr = 8'hA5;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, got, exp, $time);
  endtask

  function automatic logic [N*W-1:0] rnd();
    return (N*W)'({$urandom(), $urandom()});
  endfunction

  // reference: results from plain arithmetic, latency from the spec's polynomial
  task automatic model(input logic [N*W-1:0] v, output exp_t m);
    int unsigned a [N];
    for (int k = 0; k < N; k++) a[k] = v[k*W +: W];
    m.e[0] = 16'd2;
    m.e[1] = W'(a[2]);
    m.e[2] = W'((a[0] + a[1] + a[2]) % 65536);
    m.e[3] = (a[0] > a[1]) ? 16'd1 : 16'd0;
    m.lat = L;
`ifdef MOCK_RANDLAT_EN
    m.lat = L + int'(mlfsr % 8'd4);
    mlfsr = {mlfsr[6:0], mlfsr[7] ^ mlfsr[5] ^ mlfsr[4] ^ mlfsr[3]};
`endif
  endtask

  // one cycle of stimulus; the model decides acceptance from its own busy countdown
  task automatic drive(input logic s, input logic [N*W-1:0] v);
    exp_t m;
    @(negedge CLK);
    ST = s;
    IN = v;
    if (!RST) mrem = 0;
    else begin
      if (mrem > 0) mrem--;
      if (mrem == 0 && s) begin
        model(v, m);
        q.push_back(m);
        mrem = m.lat + 1;
        starts++;
      end
    end
  endtask

  task automatic wait_done();
    int b = 0;
    while ((q.size() != 0 || mrem != 0) && b < 100) begin
      drive(1'b0, rnd());
      b++;
    end
    if (b >= 100) begin
      total++;
      $display("FAIL drain_timeout: got %0d pending want 0", q.size());
    end
  endtask

  // monitor: samples 1 time unit after each rising edge
  always @(posedge CLK) begin
    exp_t x;
    #1;
    if (!RST) begin
      lo_cnt = 0;
      hi_run = 0;
      prev = 1'b1;
    end else begin
      if (!rd[0]) lo_cnt++;
      if (rd[0] && !prev) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL spurious_done: got completion want none at %0t", $time);
        end else begin
          x = q.pop_front();
          chk("latency", lo_cnt, x.lat);
`ifdef MOCK_RANDLAT_EN
          chk("lat_range", (lo_cnt >= 4 && lo_cnt <= 7), 1);
`endif
          cur = x.e;
          done_cnt++;
        end
        lo_cnt = 0;
        hi_run = 1;
      end else if (rd[0]) hi_run++;
      if (!rd[0] && prev) last_hi = hi_run;
      for (int k = 1; k < 4; k++) chk($sformatf("rd%0d", k), rd[k], rd[0]);
      for (int k = 0; k < 4; k++) chk($sformatf("res%0d", k), res[k], cur[k]);
      prev = rd[0];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, b;
    repeat (2) @(negedge CLK);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_rd%0d", k), rd[k], 1);
      chk($sformatf("rst_res%0d", k), res[k], 0);
    end
    RST = 1'b1;
    repeat (10) begin
      drive(1'b0, '0);
      chk("idle_rd", rd[0], 1);
    end
    drive(1'b1, {16'h0001, 16'h0002, 16'hFFFF});
    wait_done();
    s0 = starts;
    b = 0;
    drive(1'b1, {16'h1234, 16'h5555, 16'h6666});
    while (starts < s0 + 2 && b < 50) begin
      drive(1'b1, {16'hBEEF, 16'h5555, 16'h6666});
      b++;
    end
    wait_done();
    chk("b2b_gap", last_hi, 1);
    drive(1'b1, {16'h0000, 16'h0003, 16'h0005});
    wait_done();
    drive(1'b1, {16'h0000, 16'h0005, 16'h0003});
    wait_done();
    drive(1'b1, rnd());
    drive(1'b0, rnd());
    @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("abort_rd%0d", k), rd[k], 1);
      chk($sformatf("abort_res%0d", k), res[k], 0);
    end
    q.delete();
    mrem = 0;
    mlfsr = 8'hA5;
    cur = '0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (8) begin
      drive(1'b0, rnd());
      chk("post_abort_rd", rd[0], 1);
    end
    drive(1'b1, {16'h0001, 16'h0002, 16'h0003});
    wait_done();
    s0 = starts;
    b = 0;
    while (starts < s0 + 40 && b < 1000) begin
      drive(1'($urandom_range(0, 1)), rnd());
      b++;
    end
    wait_done();
    chk("start_count", starts >= s0 + 40, 1);
    chk("done_count", done_cnt, starts - 1);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/mock_func.md
Name: mock_func

Overview:
- Parametrised mock functional block for composition testbenches (if/then/else, sequential, loop composers).
- Implements the standard start/ready handshake (ST/RD) with configurable operand count, width, latency and result mode.
- Yields constant, pass-through, sum or predicate results, so one block can stand in for both the branch functions and the condition function of a composer.

Parameters:
- WIDTH, 16, bit width of every operand and of RES.
- NIN, 3, number of operands (1..8); NIN>=2 required when MODE=3.
- LATENCY, 4, cycles RD stays low per operation (>=1).
- MODE, 0, 0=CONST, 1=PASS, 2=SUM, 3=PRED.
- CONST_VAL, 2, result value when MODE=0.
- SEL_IDX, 0, operand index forwarded when MODE=1 (<NIN).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- ST  in  1  start request, sampled on the rising edge of CLK.
- RD  out  1  ready/idle; high = result valid and new start accepted.
- RES  out  WIDTH  result, held stable while RD=1.
- IN  in  NIN*WIDTH  packed operands; operand k = IN[k*WIDTH +: WIDTH].

Behaviour:
- Reset (RST=0, no clock required): RD=1, RES=0, counter=0, latched operands=0, state IDLE.
- States:
  - IDLE (RD=1).
  - BUSY (RD=0).
- IDLE:
  - Edge with ST=1: latch all NIN operands, counter<=LATENCY-1, RD<=0, go to BUSY.
  - Edge with ST=0: hold.
- BUSY:
  - Edge with counter!=0: counter decrements.
  - Edge with counter==0: RES<=f(latched operands), RD<=1, go to IDLE.
- Timing:
  - RD is low for exactly LATENCY cycles.
  - RES changes only on the completion edge, never in IDLE.
- ST handling:
  - ST is ignored while BUSY, including on the completion edge.
  - A start is accepted on the first edge with RD=1, so back-to-back operations have one RD-high cycle between them.
- IN is don't-care after latching; changes while BUSY do not affect RES.
- Result functions f:
  - CONST: CONST_VAL truncated to WIDTH.
  - PASS: operand SEL_IDX.
  - SUM: unsigned sum of all operands modulo 2^WIDTH (wrap, no carry out).
  - PRED: 1 if operand0 > operand1 (unsigned), else 0, zero-extended to WIDTH.
- Reset asserted mid-operation: aborts immediately (RD=1, RES=0); no completion occurs afterwards.
- Counter width: clog2(LATENCY+4)+1 bits, sized to cover the optional extension.

Optional Feature:
- Macro: MOCK_RANDLAT_EN.
- Enabled:
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, reset seed 8'hA5.
  - The LFSR advances exactly once per accepted start.
  - That start's latency = LATENCY + LFSR[1:0], using the value before advancing (range LATENCY..LATENCY+3).
  - Purpose: exercises composer robustness to variable latency.
- Disabled: no LFSR logic; latency is fixed at LATENCY.

Decomposition:
- Shared package/include mock_pkg:
  - MODE encodings MOCK_CONST/MOCK_PASS/MOCK_SUM/MOCK_PRED.
  - LFSR seed and tap constants.
  - Handshake state encodings IDLE/BUSY.
- One sub-module, mock_lfsr: 8-bit LFSR with advance-enable and async active-low reset, instantiated only under MOCK_RANDLAT_EN.
- Operand latch and result mux stay in mock_func.

Test Plan:
- Reset/idle: RST=0 for 2 cycles, then RST=1 with ST=0 for 10 cycles -> RD=1 and RES=0 throughout.
- Defaults (MODE=0, LATENCY=4): one-cycle ST pulse -> RD low for exactly 4 cycles, RD rises with RES=2 on the same edge.
- SUM wrap (MODE=2, WIDTH=16, NIN=3): IN={0x0001,0x0002,0xFFFF} (operands 2,1,0) -> RES=0x0002 after 4 cycles.
- Operand latch and busy-ST (MODE=1, SEL_IDX=2): operand2=0x1234 at start, changed to 0xBEEF in BUSY, ST held high throughout:
  - RES=0x1234.
  - Second op starts one cycle after RD rises.
  - Second RES=0xBEEF.
- Async abort: RST driven low mid-cycle in BUSY cycle 2 -> RD=1 and RES=0 before the next edge; after release, no spurious completion; the next ST works normally.
- PRED plus MOCK_RANDLAT_EN (MODE=3):
  - IN0=5, IN1=3 -> RES=1; IN0=3, IN1=5 -> RES=0.
  - Over 20 starts, each RD-low duration matches a reference LFSR model from seed 0xA5 and stays within 4..7.
